// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss stopwatch controller.
package stopwatch_pkg;

    localparam int BCD_W   = 4;
    localparam int SEC_MAX = 59;

    // Controller states; the encodings match the values the display/debug logic expects.
    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_ADJUST  = 2'd2
    } state_t;

    // Split a two-digit decimal constant into its BCD tens digit.
    function automatic logic [BCD_W-1:0] tens_of(input int value);
        return BCD_W'(value / 10);
    endfunction

    // Split a two-digit decimal constant into its BCD ones digit.
    function automatic logic [BCD_W-1:0] ones_of(input int value);
        return BCD_W'(value % 10);
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter that wraps to 00 after a programmable maximum.
// carry_out is combinational: it flags the increment that causes the wrap,
// so a cascaded counter can advance on the same clock edge.
module bcd2_counter
    import stopwatch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [BCD_W-1:0] max_tens,
    input  logic [BCD_W-1:0] max_ones,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             carry_out
);

    logic at_max;

    assign at_max    = (tens == max_tens) && (ones == max_ones);
    assign carry_out = inc && !clr && at_max;

    // Digit registers: clear wins, then increment with BCD ones->tens carry.
    // NOTE: sequential state is written only with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens <= '0;
            ones <= '0;
        end else if (clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (at_max) begin
                tens <= '0;
                ones <= '0;
            end else if (ones >= BCD_W'(9)) begin
                ones <= '0;
                tens <= tens + BCD_W'(1);
            end else begin
                ones <= ones + BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: press detection, STOPPED/RUNNING/ADJUST FSM,
// mm:ss BCD counting, manual field adjust and blink control for the display.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MIN_MAX    = 99,
    parameter bit SAT_AT_MAX = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             tick_adj,
    input  logic             tick_blink,
    input  logic             btn_reset,
    input  logic             btn_pause,
    input  logic             adj_en,
    input  logic             adj_sel,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             running,
    output logic             blank_min,
    output logic             blank_sec
);

    localparam logic [BCD_W-1:0] MIN_T = tens_of(MIN_MAX);
    localparam logic [BCD_W-1:0] MIN_O = ones_of(MIN_MAX);
    localparam logic [BCD_W-1:0] SEC_T = tens_of(SEC_MAX);
    localparam logic [BCD_W-1:0] SEC_O = ones_of(SEC_MAX);

    state_t state, next_state;
    logic   btn_reset_q, btn_pause_q;
    logic   press_reset, press_pause;
    logic   phase, phase_d;
    logic   at_end;
    logic   run_tick, adj_sec, adj_min;
    logic   sec_inc, min_inc, sec_carry;
    // The minutes rollover has no consumer; wrap is handled inside the counter.
    logic   min_carry_unused;

    assign press_reset = btn_reset & ~btn_reset_q;
    assign press_pause = btn_pause & ~btn_pause_q;

    assign at_end = (min_tens == MIN_T) && (min_ones == MIN_O) &&
                    (sec_tens == SEC_T) && (sec_ones == SEC_O);

    // Running ticks feed seconds and ripple into minutes; adjust ticks hit one field only.
    assign sec_inc = run_tick | adj_sec;
    assign min_inc = adj_min | (run_tick & sec_carry);

    bcd2_counter u_sec (
        .clk       (clk),
        .rst       (rst),
        .clr       (press_reset),
        .inc       (sec_inc),
        .max_tens  (SEC_T),
        .max_ones  (SEC_O),
        .tens      (sec_tens),
        .ones      (sec_ones),
        .carry_out (sec_carry)
    );

    bcd2_counter u_min (
        .clk       (clk),
        .rst       (rst),
        .clr       (press_reset),
        .inc       (min_inc),
        .max_tens  (MIN_T),
        .max_ones  (MIN_O),
        .tens      (min_tens),
        .ones      (min_ones),
        .carry_out (min_carry_unused)
    );

    // Next state and count enables, in priority order reset > adj_en > pause > ticks.
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        run_tick   = 1'b0;
        adj_sec    = 1'b0;
        adj_min    = 1'b0;
        if (press_reset) begin
            next_state = adj_en ? ST_ADJUST : ST_STOPPED;
        end else if (adj_en) begin
            next_state = ST_ADJUST;
            // Only already-settled ADJUST honours tick_adj; the entry cycle drops it.
            if (state == ST_ADJUST && tick_adj) begin
                adj_sec = ~adj_sel;
                adj_min = adj_sel;
            end
        end else begin
            unique case (state)
                ST_ADJUST:  next_state = ST_STOPPED;
                ST_STOPPED: if (press_pause) next_state = ST_RUNNING;
                ST_RUNNING: begin
                    if (tick_1hz && at_end && SAT_AT_MAX) begin
                        next_state = ST_STOPPED;
                    end else begin
                        run_tick = tick_1hz;
                        if (press_pause) next_state = ST_STOPPED;
                    end
                end
                default:    next_state = ST_STOPPED;
            endcase
        end
    end

    // Blink phase runs only while ADJUST persists; any other cycle restarts it at 0.
    assign phase_d = (state == ST_ADJUST && next_state == ST_ADJUST) ? (phase ^ tick_blink) : 1'b0;

    // State, press history, blink phase and registered display controls.
    // NOTE: only control registers are reset; there is no memory array here to leave un-reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_STOPPED;
            btn_reset_q <= 1'b0;
            btn_pause_q <= 1'b0;
            phase       <= 1'b0;
            running     <= 1'b0;
            blank_min   <= 1'b0;
            blank_sec   <= 1'b0;
        end else begin
            state       <= next_state;
            btn_reset_q <= btn_reset;
            btn_pause_q <= btn_pause;
            phase       <= phase_d;
            running     <= (next_state == ST_RUNNING);
            blank_min   <= (next_state == ST_ADJUST) & phase_d & adj_sel;
            blank_sec   <= (next_state == ST_ADJUST) & phase_d & ~adj_sel;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a saturating instance and a wrapping instance
// share all stimulus; expected values are hand-computed mm:ss constants.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick_1hz = 1'b0, tick_adj = 1'b0, tick_blink = 1'b0;
    logic btn_reset = 1'b0, btn_pause = 1'b0, adj_en = 1'b0, adj_sel = 1'b0;

    logic [BCD_W-1:0] mt, mo, st, so;
    logic             run, bmin, bsec;
    logic [BCD_W-1:0] wmt, wmo, wst, wso;
    logic             wrun, wbmin, wbsec;

    logic [15:0] digits, wdigits;
    assign digits  = {mt, mo, st, so};
    assign wdigits = {wmt, wmo, wst, wso};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.MIN_MAX(99), .SAT_AT_MAX(1'b1)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_adj(tick_adj), .tick_blink(tick_blink),
        .btn_reset(btn_reset), .btn_pause(btn_pause), .adj_en(adj_en), .adj_sel(adj_sel),
        .min_tens(mt), .min_ones(mo), .sec_tens(st), .sec_ones(so),
        .running(run), .blank_min(bmin), .blank_sec(bsec)
    );

    stopwatch_ctrl #(.MIN_MAX(99), .SAT_AT_MAX(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_adj(tick_adj), .tick_blink(tick_blink),
        .btn_reset(btn_reset), .btn_pause(btn_pause), .adj_en(adj_en), .adj_sel(adj_sel),
        .min_tens(wmt), .min_ones(wmo), .sec_tens(wst), .sec_ones(wso),
        .running(wrun), .blank_min(wbmin), .blank_sec(wbsec)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_pause_btn();
        btn_pause = 1'b1; step();
        btn_pause = 1'b0; step();
    endtask

    task automatic press_reset_btn();
        btn_reset = 1'b1; step();
        btn_reset = 1'b0; step();
    endtask

    task automatic sec_ticks(input int n);
        tick_1hz = 1'b1; step(n); tick_1hz = 1'b0;
    endtask

    task automatic adj_ticks(input int n);
        tick_adj = 1'b1; step(n); tick_adj = 1'b0;
    endtask

    task automatic blink_tick();
        tick_blink = 1'b1; step(); tick_blink = 1'b0;
    endtask

    initial begin
        // Reset state
        step(3);
        check("rst_digits", digits, 16'h0000);
        check("rst_flags", {13'd0, run, bmin, bsec}, 16'h0000);
        rst = 1'b1;
        step(2);

        // Count 125 s while running, then pause and hold
        press_pause_btn();
        check("run_start", {15'd0, run}, 16'd1);
        sec_ticks(125);
        check("count_125", digits, 16'h0205);
        check("still_run", {15'd0, run}, 16'd1);
        press_pause_btn();
        check("paused", {15'd0, run}, 16'd0);
        sec_ticks(5);
        check("pause_hold", digits, 16'h0205);

        // Preload 00:59 via adjust, one tick carries to 01:00
        press_reset_btn();
        check("btn_reset_clr", digits, 16'h0000);
        adj_en = 1'b1; step();
        adj_sel = 1'b0; adj_ticks(59);
        check("adj_0059", digits, 16'h0059);
        adj_en = 1'b0; step();
        press_pause_btn();
        sec_ticks(1);
        check("carry_0100", digits, 16'h0100);

        // Preload 99:58, run into the end of range on both variants
        press_pause_btn();
        press_reset_btn();
        adj_en = 1'b1; step();
        adj_sel = 1'b1; adj_ticks(99);
        adj_sel = 1'b0; adj_ticks(58);
        check("adj_9958", digits, 16'h9958);
        adj_en = 1'b0; step();
        press_pause_btn();
        sec_ticks(1);
        check("sat_9959", digits, 16'h9959);
        check("sat_run_before", {15'd0, run}, 16'd1);
        sec_ticks(1);
        check("sat_hold", digits, 16'h9959);
        check("sat_stopped", {15'd0, run}, 16'd0);
        check("wrap_0000", wdigits, 16'h0000);
        check("wrap_running", {15'd0, wrun}, 16'd1);
        sec_ticks(1);
        check("sat_hold2", digits, 16'h9959);
        check("wrap_0001", wdigits, 16'h0001);

        // Adjust mode: entry-cycle tick ignored, field wrap without carry, blink
        press_reset_btn();
        check("clr_wrap", wdigits, 16'h0000);
        adj_en = 1'b1; tick_adj = 1'b1; step(); tick_adj = 1'b0;
        check("adj_entry_drop", digits, 16'h0000);
        adj_sel = 1'b0; adj_ticks(61);
        check("adj_sec_wrap", digits, 16'h0001);
        adj_sel = 1'b1; adj_ticks(3);
        check("adj_min_3", digits, 16'h0301);
        check("blank_off", {14'd0, bmin, bsec}, 16'b00);
        blink_tick();
        check("blank_min_on", {14'd0, bmin, bsec}, 16'b10);
        blink_tick();
        check("blank_min_off", {14'd0, bmin, bsec}, 16'b00);
        press_pause_btn();
        check("pause_ignored_adj", {15'd0, run}, 16'd0);

        // Reset press with coincident tick while running at 05:30
        adj_sel = 1'b1; adj_ticks(2);
        adj_sel = 1'b0; adj_ticks(29);
        adj_en = 1'b0; step();
        check("adj_exit_keep", digits, 16'h0530);
        press_pause_btn();
        check("run_0530", {15'd0, run}, 16'd1);
        btn_reset = 1'b1; tick_1hz = 1'b1; step();
        btn_reset = 1'b0; tick_1hz = 1'b0;
        check("reset_drops_tick", digits, 16'h0000);
        check("reset_stops", {15'd0, run}, 16'd0);
        step();

        // Held pause button gives exactly one toggle
        btn_pause = 1'b1; step(100);
        check("held_one_toggle", {15'd0, run}, 16'd1);
        btn_pause = 1'b0; step();
        check("held_release", {15'd0, run}, 16'd1);

        // Tick coincident with pause is applied before stopping
        btn_pause = 1'b1; tick_1hz = 1'b1; step();
        btn_pause = 1'b0; tick_1hz = 1'b0;
        check("pause_tick_apply", digits, 16'h0001);
        check("pause_tick_stop", {15'd0, run}, 16'd0);
        step();

        // Async reset mid-run at 12:34 clears without a clock edge
        adj_en = 1'b1; step();
        adj_sel = 1'b1; adj_ticks(12);
        adj_sel = 1'b0; adj_ticks(33);
        adj_en = 1'b0; step();
        press_pause_btn();
        check("run_1234", digits, 16'h1234);
        #3 rst = 1'b0;
        #1;
        check("async_digits", digits, 16'h0000);
        check("async_flags", {13'd0, run, bmin, bsec}, 16'h0000);
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
